// File: rtl/send_arbiter.sv
// send_arbiter: round-robin arbiter that shares one SEND/ACK four-phase channel
// among N senders. The granted word is latched at grant time and the handshake
// is replayed downstream. The upstream ACK is closed only after the downstream
// side has completed its handshake.
module send_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 255,
  localparam int IW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_send,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ack,
  output logic           out_send,
  output logic [W-1:0]   out_data,
  input  logic           ack_in,
  output logic [IW-1:0]  grant_idx,
  output logic           busy,
  output logic           err_timeout,
  output logic [15:0]    xfer_count
);

  typedef enum logic [1:0] {IDLE, REQ, ACKD, ABORT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [W-1:0]  data_q, data_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [15:0]   xfer_q, xfer_d;
  logic          err_q, err_d;
  logic [IW-1:0] gsel;
  logic [IW-1:0] gnext;

  // First requester at or after ptr, wrapping. The last winner sits at ptr-1,
  // so it is scanned last.
  always_comb begin
    logic found;
    found = 1'b0;
    gsel  = ptr_q;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr_q) + i) % N;
      if (!found && req_send[j]) begin
        found = 1'b1;
        gsel  = IW'(j);
      end
    end
  end

  // Pointer value that moves just past the current grant.
  assign gnext = (gidx_q == IW'(N-1)) ? '0 : gidx_q + 1'b1;

  // Next-state logic: grant, downstream replay, upstream close, abort.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    xfer_d  = xfer_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_send) begin
          gidx_d  = gsel;
          data_d  = req_data[int'(gsel)*W +: W];
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ACK on the last allowed cycle still wins over the abort.
        if (ack_in) begin
          state_d = ACKD;
        end else if (tmo_q == 16'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ACKD: begin
        if (!req_send[gidx_q] && !ack_in) begin
          xfer_d  = xfer_q + 16'd1;
          ptr_d   = gnext;
          state_d = IDLE;
        end
      end
      ABORT: begin
        // The sender keeps SEND high and is simply arbitrated again later.
        if (!ack_in) begin
          ptr_d   = gnext;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      xfer_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
    end
  end

  // Per-requester ACK decode. Only the granted lane can be high, and only in ACKD.
  for (genvar i = 0; i < N; i++) begin : g_ack
    assign req_ack[i] = (state_q == ACKD) && (gidx_q == IW'(i));
  end

  assign out_send    = (state_q == REQ);
  assign out_data    = data_q;
  assign grant_idx   = gidx_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign xfer_count  = xfer_q;

endmodule
